// File: rtl/video_pkg.sv
// Shared line-fetch definitions: FSM encoding, bursts-per-line and address-step helpers.
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    localparam int WORD_BYTES = 4;

    function automatic int calc_bpl(input int h_active, input int pix_per_word, input int burst_len);
        return h_active / pix_per_word / burst_len;
    endfunction

    // True only when a line splits into a whole number of bursts
    function automatic bit bpl_exact(input int h_active, input int pix_per_word, input int burst_len);
        return (calc_bpl(h_active, pix_per_word, burst_len) >= 1) &&
               (calc_bpl(h_active, pix_per_word, burst_len) * pix_per_word * burst_len == h_active);
    endfunction

    function automatic logic [31:0] addr_step(input int burst_len);
        return 32'(burst_len * WORD_BYTES);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registered rise/fall detector for a signal already in the clk domain.
module sync_edge_det #(
    parameter logic INIT_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= INIT_LVL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= i_sig & ~r_prev;
            r_fall <= ~i_sig & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// Double-buffered scan-line fetcher: issues burst reads to fill two line buffers
// ahead of the display, restarting cleanly at each frame boundary.
module vga_line_fetch_ctrl
    import video_pkg::*;
#(
    parameter int          H_ACTIVE     = 1024,
    parameter int          V_ACTIVE     = 768,
    parameter int          PIX_PER_WORD = 2,
    parameter int          BURST_LEN    = 64,
    parameter logic [31:0] FB_BASE      = 32'h0,
    parameter logic        VS_POL       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs,
    input  logic        de,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [7:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_done,
    output logic        wr_buf,
    output logic        rd_buf,
    output logic        frame_start,
    output logic        underflow
);

    localparam int          BPL  = calc_bpl(H_ACTIVE, PIX_PER_WORD, BURST_LEN);
    localparam logic [31:0] STEP = addr_step(BURST_LEN);
    localparam int          BCW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int          LCW  = $clog2(V_ACTIVE + 1);

    generate
        if (!bpl_exact(H_ACTIVE, PIX_PER_WORD, BURST_LEN)) begin : g_bpl_check
            $error("H_ACTIVE must be a whole multiple of PIX_PER_WORD*BURST_LEN");
        end
    endgenerate

    fetch_state_t     r_state;
    logic             r_rd_req;
    logic [31:0]      r_rd_addr;
    logic [BCW-1:0]   r_burst_cnt;
    logic [LCW-1:0]   r_fetch_line;
    logic [1:0]       r_fill_cnt;
    logic             r_wr_buf;
    logic             r_rd_buf;
    logic             r_frame_start;
    logic             r_underflow;
    logic             r_restart_pend;

    logic w_vs_rise, w_vs_fall, w_de_rise, w_de_fall;
    logic w_frame_evt, w_pend, w_restart, w_last, w_line_done;

    sync_edge_det #(.INIT_LVL(~VS_POL)) u_vs_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (vs),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    sync_edge_det #(.INIT_LVL(1'b0)) u_de_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (de),
        .o_rise (w_de_rise),
        .o_fall (w_de_fall)
    );

    assign w_frame_evt = VS_POL ? w_vs_rise : w_vs_fall;
    assign w_pend      = r_restart_pend | w_frame_evt;
    // A pending restart waits for the in-flight burst to finish; that burst's line is dropped
    assign w_restart   = w_pend & ((r_state == ST_IDLE) | ((r_state == ST_WAIT) & rd_done));
    assign w_last      = (r_burst_cnt == BCW'(BPL - 1));
    assign w_line_done = (r_state == ST_WAIT) & rd_done & ~w_pend & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_rd_req       <= 1'b0;
            r_rd_addr      <= FB_BASE;
            r_burst_cnt    <= '0;
            r_fetch_line   <= LCW'(V_ACTIVE);
            r_restart_pend <= 1'b0;
            r_frame_start  <= 1'b0;
        end else if (w_restart) begin
            r_state        <= ST_IDLE;
            r_rd_req       <= 1'b0;
            r_rd_addr      <= FB_BASE;
            r_burst_cnt    <= '0;
            r_fetch_line   <= '0;
            r_restart_pend <= 1'b0;
            r_frame_start  <= 1'b1;
        end else begin
            r_frame_start <= 1'b0;
            if (w_frame_evt) r_restart_pend <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if ((r_fill_cnt < 2'd2) && (r_fetch_line < LCW'(V_ACTIVE))) begin
                        r_state  <= ST_REQ;
                        r_rd_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (rd_ack) begin
                        r_state  <= ST_WAIT;
                        r_rd_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (rd_done) begin
                        r_rd_addr <= r_rd_addr + STEP;
                        if (w_last) begin
                            r_burst_cnt  <= '0;
                            r_fetch_line <= r_fetch_line + 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                            r_state     <= ST_REQ;
                            r_rd_req    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_rd_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt  <= 2'd0;
            r_wr_buf    <= 1'b0;
            r_rd_buf    <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_de_rise && (r_fill_cnt == 2'd0)) r_underflow <= 1'b1;
            if (w_restart) begin
                r_fill_cnt <= 2'd0;
                r_wr_buf   <= 1'b0;
                r_rd_buf   <= 1'b0;
            end else begin
                if (w_line_done) r_wr_buf <= ~r_wr_buf;
                if (w_de_fall)   r_rd_buf <= ~r_rd_buf;
                // Fill and drain in the same cycle cancel out
                if (w_line_done && !w_de_fall)
                    r_fill_cnt <= r_fill_cnt + 2'd1;
                else if (!w_line_done && w_de_fall && (r_fill_cnt != 2'd0))
                    r_fill_cnt <= r_fill_cnt - 2'd1;
            end
        end
    end

    assign rd_req      = r_rd_req;
    assign rd_addr     = r_rd_addr;
    assign rd_len      = 8'(BURST_LEN);
    assign wr_buf      = r_wr_buf;
    assign rd_buf      = r_rd_buf;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Scoreboard bench: stimulus queues expected burst addresses and frame_start pulses,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_vga_line_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, vs, de, rd_ack, rd_done;
    logic        rd_req, wr_buf, rd_buf, frame_start, underflow;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;
    int exp_fs   = 0;
    int resp_en, ack_dly, done_dly;
    logic [31:0] exp_addr[$];

    always #5 clk = ~clk;

    vga_line_fetch_ctrl #(
        .H_ACTIVE(256), .V_ACTIVE(4), .PIX_PER_WORD(2), .BURST_LEN(64),
        .FB_BASE(32'h1000), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vs(vs), .de(de),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_ack(rd_ack), .rd_done(rd_done),
        .wr_buf(wr_buf), .rd_buf(rd_buf),
        .frame_start(frame_start), .underflow(underflow)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic nclk(input int n);
        repeat (n) tick();
    endtask

    task automatic de_pulse();
        de = 1'b1; nclk(4);
        de = 1'b0; nclk(4);
    endtask

    task automatic vs_event();
        vs = 1'b1; tick();
        vs = 1'b0; tick();
    endtask

    task automatic push4(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_addr.push_back(base + 32'(i * 256));
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_addr.size() != 0 && k < 600) begin @(negedge clk); k++; end
        chk(name, 32'(exp_addr.size()), 32'd0);
    endtask

    // Memory model: ack after ack_dly cycles, rd_done done_dly cycles after the ack
    initial begin
        rd_ack = 1'b0; rd_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (resp_en != 0 && rst_n && rd_req) begin
                repeat (ack_dly - 1) begin @(posedge clk); #1; end
                rd_ack = 1'b1; @(posedge clk); #1; rd_ack = 1'b0;
                repeat (done_dly - 1) begin @(posedge clk); #1; end
                rd_done = 1'b1; @(posedge clk); #1; rd_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_req && rd_ack) begin
                hs_cnt++;
                if (exp_addr.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_req: got addr 0x%0h expected no request", rd_addr);
                end else begin
                    chk("rd_addr", rd_addr, exp_addr.pop_front());
                end
            end
            if (frame_start) begin
                if (exp_fs == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_frame_start: got pulse expected none");
                end else begin
                    exp_fs--;
                    chk("fs_addr", rd_addr, 32'h1000);
                    chk("fs_req", {31'd0, rd_req}, 32'd0);
                end
            end
        end
    end

    initial begin
        int hs0, k;
        rst_n = 1'b0; vs = 1'b1; de = 1'b0;
        resp_en = 1; ack_dly = 1; done_dly = 10;
        nclk(3);
        @(negedge clk);
        chk("rst_req",   {31'd0, rd_req}, 32'd0);
        chk("rst_addr",  rd_addr, 32'h1000);
        chk("rst_len",   {24'd0, rd_len}, 32'd64);
        chk("rst_wrbuf", {31'd0, wr_buf}, 32'd0);
        chk("rst_rdbuf", {31'd0, rd_buf}, 32'd0);
        chk("rst_fs",    {31'd0, frame_start}, 32'd0);
        chk("rst_uf",    {31'd0, underflow}, 32'd0);
        tick(); rst_n = 1'b1;
        nclk(10);
        chk("idle_no_req", 32'(hs_cnt), 32'd0);

        // Two lines fetched after frame start, then the fetcher holds
        exp_fs++; push4(32'h1000);
        vs_event();
        wait_drain("t1_drain");
        nclk(30);
        chk("t1_bursts", 32'(hs_cnt), 32'd4);
        chk("t1_req_idle", {31'd0, rd_req}, 32'd0);
        chk("t1_wrbuf", {31'd0, wr_buf}, 32'd0);

        // One line consumed -> line 2 fetched
        exp_addr.push_back(32'h1400); exp_addr.push_back(32'h1500);
        de_pulse();
        wait_drain("t2_drain");
        nclk(30);
        chk("t2_rdbuf", {31'd0, rd_buf}, 32'd1);
        chk("t2_wrbuf", {31'd0, wr_buf}, 32'd1);
        chk("t2_uf", {31'd0, underflow}, 32'd0);

        // Slow ack: request held steady for 20 cycles
        ack_dly = 21;
        exp_addr.push_back(32'h1600); exp_addr.push_back(32'h1700);
        de = 1'b1; nclk(4); de = 1'b0;
        k = 0;
        while (!rd_req && k < 40) begin @(negedge clk); k++; end
        hs0 = hs_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            chk("t3_req_hold", {31'd0, rd_req}, 32'd1);
            chk("t3_addr_hold", rd_addr, 32'h1600);
        end
        repeat (15) @(negedge clk);
        chk("t3_one_burst", 32'(hs_cnt - hs0), 32'd1);
        wait_drain("t3_drain");
        ack_dly = 1;
        nclk(30);

        // All lines fetched: draining buffers issues nothing
        hs0 = hs_cnt;
        de_pulse(); de_pulse();
        nclk(20);
        chk("t4_no_fetch", 32'(hs_cnt - hs0), 32'd0);
        chk("t4_uf_clear", {31'd0, underflow}, 32'd0);
        de_pulse();
        chk("t4_uf_set", {31'd0, underflow}, 32'd1);

        // Frame event during WAIT of burst 1 discards that line
        done_dly = 20;
        hs0 = hs_cnt;
        exp_fs++; exp_addr.push_back(32'h1000); exp_addr.push_back(32'h1100);
        vs_event();
        k = 0;
        while (hs_cnt < hs0 + 2 && k < 200) begin @(negedge clk); k++; end
        chk("t5_burst1_seen", 32'(hs_cnt - hs0), 32'd2);
        tick();
        exp_fs++; push4(32'h1000);
        vs = 1'b1; tick(); vs = 1'b0;
        k = 0;
        @(negedge clk);
        while (!frame_start && k < 60) begin
            chk("t5_no_req", {31'd0, rd_req}, 32'd0);
            @(negedge clk); k++;
        end
        chk("t5_fs_seen", {31'd0, frame_start}, 32'd1);
        chk("t5_wrbuf", {31'd0, wr_buf}, 32'd0);
        chk("t5_rdbuf", {31'd0, rd_buf}, 32'd0);
        done_dly = 10;
        wait_drain("t5_drain");
        nclk(40);
        chk("t5_bursts", 32'(hs_cnt - hs0), 32'd6);
        chk("t5_uf_sticky", {31'd0, underflow}, 32'd1);

        // Reset while a request is pending
        resp_en = 0; vs = 1'b1;
        de_pulse();
        k = 0;
        while (!rd_req && k < 20) begin @(negedge clk); k++; end
        chk("t6_req_up", {31'd0, rd_req}, 32'd1);
        @(posedge clk); #3; rst_n = 1'b0; #1;
        chk("t6_req_async", {31'd0, rd_req}, 32'd0);
        chk("t6_addr_async", rd_addr, 32'h1000);
        nclk(3); rst_n = 1'b1; resp_en = 1;
        hs0 = hs_cnt;
        nclk(20);
        chk("t6_no_req", 32'(hs_cnt - hs0), 32'd0);
        chk("t6_uf_reset", {31'd0, underflow}, 32'd0);
        exp_fs++; push4(32'h1000);
        vs_event();
        wait_drain("t6_drain");
        nclk(30);
        chk("t6_bursts", 32'(hs_cnt - hs0), 32'd4);
        chk("fs_all_seen", 32'(exp_fs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_line_fetch_ctrl.md
VGA_LINE_FETCH_CTRL -- requirements
Module: vga_line_fetch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 1024, active pixels per line.
- V_ACTIVE, 768, active lines per frame.
- PIX_PER_WORD, 2, pixels per 32-bit memory word.
- BURST_LEN, 64, words per read burst.
- FB_BASE, 32'h0, frame buffer byte base address.
- VS_POL, 1'b0, sync-asserted level of vs.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, pixel clock; single clock domain.
- rst_n, in, 1, reset, asynchronous, active-low.
- vs, in, 1, vertical sync from the timing generator.
- de, in, 1, video-valid from the timing generator.
- rd_req, out, 1, burst read request.
- rd_addr, out, 32, burst byte address.
- rd_len, out, 8, burst length in words (constant BURST_LEN).
- rd_ack, in, 1, request accepted.
- rd_done, in, 1, one-cycle pulse: last word of the accepted burst written.
- wr_buf, out, 1, line buffer currently being filled.
- rd_buf, out, 1, line buffer currently being displayed.
- frame_start, out, 1, one-cycle pulse on frame restart.
- underflow, out, 1, sticky flag: a line started with no filled buffer.

Function
REQ-003 BPL = H_ACTIVE/PIX_PER_WORD/BURST_LEN bursts per line SHALL be an integer; elaboration SHALL fail otherwise.
REQ-004 Frame event SHALL be detected as vs transitioning to VS_POL (registered edge detect, one cycle latency).
REQ-005 FSM states SHALL be IDLE, REQ, WAIT.
REQ-006 IDLE->REQ SHALL occur when fill_cnt<2, fetch_line<V_ACTIVE and no restart is pending.
REQ-007 In REQ, rd_req=1 and rd_addr SHALL be held stable until the cycle with rd_ack=1, then go to WAIT.
REQ-008 In WAIT, on rd_done: rd_addr += BURST_LEN*4; burst_cnt increments.
REQ-009 On the last burst of a line (burst_cnt==BPL-1): burst_cnt=0, fetch_line++, fill_cnt++, wr_buf toggles, FSM->IDLE; otherwise FSM->REQ.
REQ-010 rd_done or rd_ack outside WAIT/REQ respectively SHALL be ignored.
REQ-011 Line consumption SHALL be the falling edge of de: fill_cnt--, rd_buf toggles; fill_cnt SHALL saturate at 0.
REQ-012 A rising edge of de while fill_cnt==0 SHALL set underflow, held until reset.
REQ-013 Line completion and consumption in the same cycle SHALL leave fill_cnt unchanged and toggle both wr_buf and rd_buf.
REQ-014 A frame event SHALL set restart_pending; an in-flight burst SHALL complete (REQ through ack, WAIT through rd_done), never be abandoned.
REQ-015 Restart SHALL be applied in IDLE, or in WAIT on rd_done (the burst's line is then discarded): fetch_line=0, burst_cnt=0, fill_cnt=0, rd_addr=FB_BASE, wr_buf=rd_buf=0, frame_start pulses for 1 cycle, pending cleared.
REQ-016 A frame event while restart_pending is set SHALL merge with it (one frame_start).
REQ-017 After fetch_line==V_ACTIVE, no request SHALL issue until restart.

Reset
REQ-018 rst_n low SHALL asynchronously force: FSM=IDLE, rd_req=0, rd_addr=FB_BASE, rd_len=BURST_LEN, wr_buf=0, rd_buf=0, frame_start=0, underflow=0, fill_cnt=0, fetch_line=V_ACTIVE (idle until first frame event), vs/de edge registers to inactive.
REQ-019 Reset deassertion mid-burst SHALL not issue rd_req before the first frame event.

Structure
REQ-020 BPL, the FSM state encoding and the address-step constant SHALL reside in a shared package video_pkg.
REQ-021 A sub-module sync_edge_det (registered rise/fall detect) SHALL be instantiated for vs and de.

Verification (bench params H_ACTIVE=256, PIX_PER_WORD=2, BURST_LEN=64 -> BPL=2, V_ACTIVE=4, FB_BASE=32'h1000)
REQ-022 vs falls, rd_ack and rd_done after 1/10 cycles -> frame_start 1 pulse; addresses 0x1000, 0x1100, 0x1200, 0x1300; stops at fill_cnt=2 with wr_buf=0.
REQ-023 rd_ack held low 20 cycles -> rd_req and rd_addr stable all 20 cycles; exactly one burst counted.
REQ-024 de pulse after two lines filled -> rd_buf toggles to 1, next request addr 0x1400 follows.
REQ-025 de rises with fill_cnt=0 -> underflow=1 and stays 1 through later frames until rst_n low.
REQ-026 vs event during WAIT of burst 1 -> no new rd_req until rd_done; then frame_start, next rd_addr=0x1000, fill_cnt=0.
REQ-027 rst_n low in REQ -> rd_req=0 same cycle without a clock edge; no request until the next vs event.
